// File: rtl/hex_display_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package hex_display_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [NUM_DIGITS-1:0][3:0] hex_digits_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/hex_display_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after index start, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk the requesters from start, taking the first one that is asking.
  always_comb begin
    int k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit scanned display among NUM_REQ
// requesters, with a minimum dwell per grant and per-digit blinking.
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DWELL      = 50_000_000,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic                                     clk,
  input  logic                                     clr,
  input  logic [NUM_REQ-1:0]                       req,
  input  logic [NUM_REQ-1:0][NUM_DIGITS-1:0][3:0]  value,
  input  logic [NUM_REQ-1:0][NUM_DIGITS-1:0]       dots,
  input  logic [NUM_REQ-1:0][NUM_DIGITS-1:0]       digit_en,
  input  logic [NUM_REQ-1:0][NUM_DIGITS-1:0]       blink,
  output logic [NUM_REQ-1:0]                       gnt,
  output logic                                     busy,
  output logic [NUM_DIGITS-1:0]                    en,
  output logic [NUM_DIGITS-1:0][3:0]               display,
  output logic [NUM_DIGITS-1:0]                    dots_out
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [OW-1:0] LAST_IDX   = OW'(NUM_REQ - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + OW'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] i);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  arb_state_t         state, state_nxt;
  logic [OW-1:0]      owner, owner_nxt;
  logic [OW-1:0]      ptr, ptr_nxt;
  logic [DW-1:0]      dwell_cnt, dwell_nxt;
  logic [BW-1:0]      blink_cnt, blink_cnt_nxt;
  logic               blink_phase, blink_phase_nxt;

  logic [NUM_REQ-1:0] others;
  logic [OW-1:0]      owner_succ;
  logic               idle_found, hold_found;
  logic [OW-1:0]      idle_idx, hold_idx;

  hex_digits_t        sel_value;
  logic [NUM_DIGITS-1:0] sel_dots, sel_en;

  assign others     = req & ~onehot(owner);
  assign owner_succ = wrap_inc(owner);

  rr_pick #(.N(NUM_REQ), .IW(OW)) u_pick_idle (
    .req   (req),
    .start (ptr),
    .found (idle_found),
    .idx   (idle_idx)
  );

  rr_pick #(.N(NUM_REQ), .IW(OW)) u_pick_hold (
    .req   (others),
    .start (owner_succ),
    .found (hold_found),
    .idx   (hold_idx)
  );

  // Arbitration: owner release beats dwell expiry; an expired dwell with
  // nobody else waiting keeps the owner with the counter parked at the top.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    dwell_nxt = (dwell_cnt == DWELL_LAST) ? dwell_cnt : dwell_cnt + DW'(1);
    case (state)
      IDLE: begin
        dwell_nxt = '0;
        if (idle_found) begin
          owner_nxt = idle_idx;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!req[owner]) begin
          ptr_nxt   = owner_succ;
          dwell_nxt = '0;
          if (hold_found) owner_nxt = hold_idx;
          else            state_nxt = IDLE;
        end else if (dwell_cnt == DWELL_LAST && hold_found) begin
          owner_nxt = hold_idx;
          ptr_nxt   = wrap_inc(hold_idx);
          dwell_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Free-running blink timebase, independent of grants.
  always_comb begin
    if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end else begin
      blink_cnt_nxt   = blink_cnt + BW'(1);
      blink_phase_nxt = blink_phase;
    end
  end

  assign sel_value = value[owner_nxt];
  assign sel_dots  = dots[owner_nxt];
  assign sel_en    = digit_en[owner_nxt] &
                     ~(blink[owner_nxt] & {NUM_DIGITS{blink_phase_nxt}});

  // Arbitration and blink state registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= '0;
      dwell_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      ptr         <= ptr_nxt;
      dwell_cnt   <= dwell_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
    end
  end

  // Output image: grant and image update on the same edge; idle keeps the
  // last digits and dots but blanks all enables.
  always_ff @(posedge clk) begin
    if (clr) begin
      gnt      <= '0;
      busy     <= 1'b0;
      en       <= '0;
      display  <= '0;
      dots_out <= '0;
    end else if (state_nxt == HOLD) begin
      gnt      <= onehot(owner_nxt);
      busy     <= 1'b1;
      en       <= sel_en;
      display  <= sel_value;
      dots_out <= sel_dots;
    end else begin
      gnt      <= '0;
      busy     <= 1'b0;
      en       <= '0;
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with NUM_REQ=3, DWELL=4, BLINK_HALF=3.
module tb_hex_display_arbiter;

  localparam int NUM_REQ    = 3;
  localparam int DWELL      = 4;
  localparam int BLINK_HALF = 3;

  logic                        clk;
  logic                        clr;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0][7:0][3:0] value;
  logic [NUM_REQ-1:0][7:0]     dots;
  logic [NUM_REQ-1:0][7:0]     digit_en;
  logic [NUM_REQ-1:0][7:0]     blink;
  logic [NUM_REQ-1:0]          gnt;
  logic                        busy;
  logic [7:0]                  en;
  logic [7:0][3:0]             display;
  logic [7:0]                  dots_out;

  int compared   = 0;
  int mismatched = 0;

  hex_display_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DWELL      (DWELL),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .value    (value),
    .dots     (dots),
    .digit_en (digit_en),
    .blink    (blink),
    .gnt      (gnt),
    .busy     (busy),
    .en       (en),
    .display  (display),
    .dots_out (dots_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt),      32'h0);
    chk({tag, "_busy"}, 32'(busy),     32'h0);
    chk({tag, "_en"},   32'(en),       32'h0);
    chk({tag, "_disp"}, 32'(display),  32'h0);
    chk({tag, "_dots"}, 32'(dots_out), 32'h0);
  endtask

  // Two reset cycles with the given requests already applied, then release.
  task automatic do_reset(input logic [NUM_REQ-1:0] r);
    clr = 1'b1;
    req = r;
    step();
    chk_zero("rst1");
    step();
    chk_zero("rst2");
    clr = 1'b0;
  endtask

  initial begin
    int idx;
    logic [31:0] exp_en;

    clr         = 1'b1;
    req         = '0;
    value[0]    = 32'hA0A0_0001;
    value[1]    = 32'hB1B1_0002;
    value[2]    = 32'hC2C2_0003;
    dots[0]     = 8'h01;
    dots[1]     = 8'h02;
    dots[2]     = 8'h04;
    digit_en    = {NUM_REQ{8'hFF}};
    blink       = '0;

    // Reset with every requester asking, then round-robin with req=111.
    do_reset(3'b111);
    for (int k = 1; k <= 13; k++) begin
      step();
      idx = ((k - 1) / 4) % 3;
      chk("rr_gnt",  32'(gnt),     32'(1 << idx));
      chk("rr_disp", 32'(display), 32'(value[idx]));
      if (k == 1) begin
        chk("first_busy", 32'(busy),     32'h1);
        chk("first_en",   32'(en),       32'hFF);
        chk("first_dots", 32'(dots_out), 32'h01);
      end
    end

    // Early release: owner 0 drops at dwell cycle 1, requester 1 takes over.
    do_reset(3'b011);
    step();
    chk("er_gnt0", 32'(gnt), 32'h1);
    step();
    chk("er_gnt1", 32'(gnt), 32'h1);
    req = 3'b010;
    step();
    chk("er_switch_gnt",  32'(gnt),     32'h2);
    chk("er_switch_disp", 32'(display), 32'(value[1]));
    chk("er_switch_dots", 32'(dots_out), 32'h02);
    req = 3'b011;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("er_hold_gnt", 32'(gnt), 32'h2);
    end
    step();
    chk("er_next_gnt", 32'(gnt), 32'h1);
    req = 3'b000;
    step();
    chk("er_idle_gnt",  32'(gnt),     32'h0);
    chk("er_idle_busy", 32'(busy),    32'h0);
    chk("er_idle_en",   32'(en),      32'h0);
    chk("er_idle_disp", 32'(display), 32'(value[0]));

    // Sole owner keeps the display; a late request is granted one edge later.
    req = 3'b100;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("sole_gnt", 32'(gnt), 32'h4);
    end
    req = 3'b101;
    step();
    chk("late_gnt",  32'(gnt),     32'h1);
    chk("late_disp", 32'(display), 32'(value[0]));

    // Blink: owner 1 with the low nibble of digits blinking.
    blink[1] = 8'h0F;
    do_reset(3'b010);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_en = (((k / 3) % 2) == 1) ? 32'hF0 : 32'hFF;
      chk("blink_en", 32'(en), exp_en);
      if (k == 1) chk("blink_gnt", 32'(gnt), 32'h2);
    end
    blink = '0;

    // Mid-grant reset during owner 1's third dwell cycle.
    do_reset(3'b011);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) chk("mid_gnt_own1", 32'(gnt), 32'h2);
      if (k == 7) chk("mid_gnt_dw2",  32'(gnt), 32'h2);
    end
    clr = 1'b1;
    step();
    chk_zero("mid_rst");
    clr = 1'b0;
    req = 3'b110;
    step();
    chk("mid_rearb_gnt",  32'(gnt),     32'h2);
    chk("mid_rearb_disp", 32'(display), 32'(value[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the 8-digit scanned seven-segment display between up to NUM_REQ independent requesters (CPU MMIO port, debug monitor, error reporter, ...). It grants the display to one requester at a time, round-robin, with a minimum dwell time so a granted image stays readable. It applies per-digit blinking and drives the existing `hex7seg` scan driver's `en`, `display` and `dots` inputs from registered outputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DWELL`, default 50_000_000: minimum grant length in clk cycles, ≥2.
- `BLINK_HALF`, default 25_000_000: blink half-period in clk cycles, ≥1.

- `clk` in 1: system clock; sole clock domain.
- `clr` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: request, held high while the requester wants the display.
- `value` in [NUM_REQ][7:0][3:0]: per-requester hex nibbles, digit 0 rightmost.
- `dots` in [NUM_REQ][7:0]: per-requester decimal points, 1 = lit.
- `digit_en` in [NUM_REQ][7:0]: per-requester digit enables, 1 = digit shown.
- `blink` in [NUM_REQ][7:0]: per-requester blink mask, 1 = digit blinks.
- `gnt` out NUM_REQ: one-hot grant, all-zero when idle.
- `busy` out 1: a grant is active.
- `en` out 8: digit enables to the scan driver.
- `display` out [7:0][3:0]: nibbles to the scan driver.
- `dots_out` out 8: decimal points to the scan driver.

## Operation
- FSM has two states, IDLE and HOLD. An `owner` index register and a round-robin pointer `ptr` hold the arbitration state. `ptr` is the index searched first.
- IDLE: `gnt`=0, `busy`=0, `en`=0. If any `req` is high, grant the first requester at or after `ptr` (wrapping), load `dwell_cnt`=0, and go to HOLD.
- HOLD: `dwell_cnt` increments each cycle and saturates at DWELL-1. Priority of events, highest first:
  - Owner drops `req`: release immediately. Set `ptr` = owner+1 mod NUM_REQ. If another `req` is high, grant the next one after the owner in the same cycle with `dwell_cnt`=0. Otherwise go to IDLE.
  - `dwell_cnt`==DWELL-1 and another requester is pending: grant the first pending requester after the owner (wrapping), reset `dwell_cnt`, and set `ptr` = new owner+1.
  - `dwell_cnt`==DWELL-1 with no other requester pending: keep the owner. The counter stays saturated, so any later request is granted on the next cycle.
- Data path: each cycle `display`, `dots_out` and `en` register the next owner's `value`, `dots` and `digit_en`. Live updates from the owner therefore show with 1 cycle of latency.
- Masking: when idle, `en`=0 and `display`/`dots_out` hold their last values. When granted, `en` = `digit_en` & ~(`blink` & {8{blink_phase}}).
- Blink: `blink_cnt` runs from reset, independent of grants. It wraps at BLINK_HALF-1 and toggles `blink_phase` on each wrap.
- Widths: `dwell_cnt` is $clog2(DWELL) bits. `blink_cnt` is $clog2(BLINK_HALF) bits, minimum 1. `owner` and `ptr` are $clog2(NUM_REQ) bits, minimum 1.
- Any `clr` mid-grant aborts immediately. All state returns to reset values.

## Timing
- Reset values: `gnt`=0, `busy`=0, `en`=0, `display`=0, `dots_out`=0, `ptr`=0, `owner`=0, `dwell_cnt`=0, `blink_cnt`=0, `blink_phase`=0, state IDLE.
- `req` rising in cycle t: `gnt`/`busy` and the new outputs appear after the edge ending cycle t (1-cycle latency).
- Owner `req` falling in cycle t: `gnt` changes or clears after the same edge. `en` goes to 0 at that edge if no other requester is pending.
- With competing requesters, a grant lasts exactly DWELL cycles of `gnt` high before switching. There is no gap cycle between consecutive grants.
- `gnt`, `en`, `display` and `dots_out` always change on the same edge, so there is never a mixed image.
- `blink_phase` toggles every BLINK_HALF cycles. The first toggle is at the end of cycle BLINK_HALF-1 after reset release.

## Structure
- Package `hex_display_pkg`:
  - typedef `hex_digits_t` = logic [7:0][3:0].
  - typedef `arb_state_t` enum {IDLE, HOLD}.
  - constant `NUM_DIGITS`=8.
- Sub-module `rr_pick`: combinational first-set-bit search starting at a given index with wrap. It is used for both the IDLE and HOLD selections.
- Top level is instantiated beside `hex7seg`. `en`/`display`/`dots_out` connect to its `en`/`display`/`dots`.

## Test plan
Bench parameters: NUM_REQ=3, DWELL=4, BLINK_HALF=3.
- Reset: hold `clr` 2 cycles with all `req` high. All outputs stay 0 during reset. After release, `gnt`=3'b001 one cycle later, and `display` equals `value[0]`.
- Round-robin: `req`=3'b111 held. `gnt` sequence is 001×4, 010×4, 100×4, 001… with no idle cycle between grants.
- Early release: `req`=3'b011, owner 0 drops `req` at dwell cycle 1. `gnt`=3'b010 after the next edge with the dwell restarted. Then `req`=0 gives `gnt`=0, `busy`=0, `en`=0.
- Sole owner: only `req[2]` high for 20 cycles, so `gnt` stays 3'b100. Then raise `req[0]`: `gnt`=3'b001 one edge later.
- Blink: owner 1 with `digit_en`=8'hFF and `blink`=8'h0F. `en` alternates 8'hFF / 8'hF0 every 3 cycles, in phase with `blink_cnt`.
- Mid-grant reset: pulse `clr` at dwell cycle 2 of owner 1. All outputs are 0 the next cycle. Re-arbitration restarts from `ptr`=0.
